calc_port_responder: RTL and testbench

Single-port responder for the calculator request/response protocol: accepts a two-cycle request (command plus operand 1, then operand 2), executes add/subtract/shift, and returns a one-cycle response code with result data. It is the answering end of the interface the calc1 benches drive. It serves as a synthesizable reference model and as a per-port execution slice for a future multi-port calculator.

---
 rtl/calc_port_responder_if.sv | 26 ++
 rtl/calc_port_responder.sv | 159 +++++++++++++++
 tb/tb_calc_port_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/calc_port_responder_if.sv
// Request/response bundle for one calculator port.
// The master drives requests. The slave (the responder) returns the response code,
// the result data and busy.
interface calc_port_responder_if;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  modport master (
    output req_cmd_in,
    output req_data_in,
    input  out_resp,
    input  out_data,
    input  busy
  );

  modport slave (
    input  req_cmd_in,
    input  req_data_in,
    output out_resp,
    output out_data,
    output busy
  );
endinterface

// File: rtl/calc_port_responder.sv
// Single-port calculator responder.
// A request takes two cycles: command plus operand 1, then operand 2.
// The block executes add, subtract or a logical shift.
// It returns a one-cycle registered response RESP_DELAY cycles after the operand-2 cycle.
// Bit 0 is the MSB of every bus; bit 31 of the data buses is the LSB.
module calc_port_responder #(
  parameter int unsigned RESP_DELAY = 1
) (
  input  logic                  c_clk,
  input  logic                  reset_n,
  calc_port_responder_if.slave  bus
);

  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [3:0] DLY = 4'(RESP_DELAY);

  localparam logic [0:1] RESP_OK  = 2'd1;
  localparam logic [0:1] RESP_ERR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [0:3]  cmd_q, cmd_d;
  logic [0:31] op1_q, op1_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:1]  res_resp_q, res_resp_d;
  logic [0:31] res_data_q, res_data_d;
  logic [0:1]  out_resp_q, out_resp_d;
  logic [0:31] out_data_q, out_data_d;
  logic        busy_q, busy_d;

  logic [0:1]  calc_resp;
  logic [0:31] calc_data;
  logic [32:0] sum33;

  // State, captured request, result and registered outputs.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      cnt_q      <= '0;
      res_resp_q <= '0;
      res_data_q <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      cnt_q      <= cnt_d;
      res_resp_q <= res_resp_d;
      res_data_q <= res_data_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
    end
  end

  // Execute the latched command against operand 2, which is present on req_data_in in the OP2 cycle.
  always_comb begin
    calc_resp = RESP_ERR;
    calc_data = '0;
    sum33     = {1'b0, op1_q} + {1'b0, bus.req_data_in};
    unique case (cmd_q)
      CMD_ADD: begin
        if (!sum33[32]) begin
          calc_resp = RESP_OK;
          calc_data = sum33[31:0];
        end
      end
      CMD_SUB: begin
        if (bus.req_data_in <= op1_q) begin
          calc_resp = RESP_OK;
          calc_data = op1_q - bus.req_data_in;
        end
      end
      CMD_SHL: begin
        calc_resp = RESP_OK;
        calc_data = op1_q << bus.req_data_in[27:31];
      end
      CMD_SHR: begin
        calc_resp = RESP_OK;
        calc_data = op1_q >> bus.req_data_in[27:31];
      end
      default: ;
    endcase
  end

  // Next-state logic, request capture and the delay counter.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    cnt_d      = cnt_q;
    res_resp_d = res_resp_q;
    res_data_d = res_data_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_cmd_in != '0) begin
          state_d = S_OP2;
          cmd_d   = bus.req_cmd_in;
          op1_d   = bus.req_data_in;
        end
      end
      S_OP2: begin
        res_resp_d = calc_resp;
        res_data_d = calc_data;
        cnt_d      = 4'd1;
        state_d    = (DLY == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == DLY) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state, so they change only at clock edges.
  // With zero delay, RESP follows OP2 directly, so the result is taken straight from the execute logic.
  always_comb begin
    out_resp_d = '0;
    out_data_d = '0;
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_RESP) begin
      if (state_q == S_OP2) begin
        out_resp_d = calc_resp;
        out_data_d = calc_data;
      end else begin
        out_resp_d = res_resp_q;
        out_data_d = res_data_q;
      end
    end
  end

  assign bus.out_resp = out_resp_q;
  assign bus.out_data = out_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder.
// Three instances are built, with RESP_DELAY of 1, 3 and 0.
// Expected responses are queued when a request is driven and popped in the response cycle.
module tb_calc_port_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [0:3]  cmd_v   [3];
  logic [0:31] data_v  [3];
  logic [0:1]  resp_v  [3];
  logic [0:31] rdata_v [3];
  logic        busy_v  [3];

  logic [33:0] sb [$];

  calc_port_responder_if if_d1 ();
  calc_port_responder_if if_d3 ();
  calc_port_responder_if if_d0 ();

  assign if_d1.req_cmd_in  = cmd_v[0];
  assign if_d1.req_data_in = data_v[0];
  assign if_d3.req_cmd_in  = cmd_v[1];
  assign if_d3.req_data_in = data_v[1];
  assign if_d0.req_cmd_in  = cmd_v[2];
  assign if_d0.req_data_in = data_v[2];

  assign resp_v[0]  = if_d1.out_resp;
  assign rdata_v[0] = if_d1.out_data;
  assign busy_v[0]  = if_d1.busy;
  assign resp_v[1]  = if_d3.out_resp;
  assign rdata_v[1] = if_d3.out_data;
  assign busy_v[1]  = if_d3.busy;
  assign resp_v[2]  = if_d0.out_resp;
  assign rdata_v[2] = if_d0.out_data;
  assign busy_v[2]  = if_d0.busy;

  calc_port_responder #(.RESP_DELAY(1)) u_d1 (.c_clk(clk), .reset_n(rst_n), .bus(if_d1.slave));
  calc_port_responder #(.RESP_DELAY(3)) u_d3 (.c_clk(clk), .reset_n(rst_n), .bus(if_d3.slave));
  calc_port_responder #(.RESP_DELAY(0)) u_d0 (.c_clk(clk), .reset_n(rst_n), .bus(if_d0.slave));

  function automatic int unsigned dly(input int unsigned sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  // {busy, resp, data} of one instance
  function automatic logic [34:0] outs(input int unsigned sel);
    return {busy_v[sel], resp_v[sel], rdata_v[sel]};
  endfunction

  // Full transaction with cycle-by-cycle output checks.
  // When noise is set, a command is driven while the instance is busy.
  task automatic send(input int unsigned sel, input logic [0:3] cmd,
                      input logic [0:31] op1, input logic [0:31] op2,
                      input logic [0:1] exp_r, input logic [0:31] exp_d,
                      input bit noise);
    logic [33:0] e;
    @(negedge clk);
    cmd_v[sel]  = cmd;
    data_v[sel] = op1;
    @(negedge clk);
    chk("op2_cycle", 64'(outs(sel)), 64'({1'b1, 2'd0, 32'd0}));
    data_v[sel] = op2;
    sb.push_back({exp_r, exp_d});
    @(negedge clk);
    cmd_v[sel]  = noise ? 4'd1 : 4'd0;
    data_v[sel] = noise ? 32'h0000_00AA : 32'd0;
    for (int unsigned i = 0; i < dly(sel); i++) begin
      chk("wait_cycle", 64'(outs(sel)), 64'({1'b1, 2'd0, 32'd0}));
      @(negedge clk);
      cmd_v[sel]  = '0;
      data_v[sel] = '0;
    end
    e = sb.pop_front();
    chk("response", 64'(outs(sel)), 64'({1'b1, e}));
    @(negedge clk);
    cmd_v[sel]  = '0;
    data_v[sel] = '0;
    chk("after_resp", 64'(outs(sel)), 64'd0);
    if (noise) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_second_resp", 64'(outs(sel)), 64'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cmd_v[i]  = '0;
      data_v[i] = '0;
    end

    // Reset held with a command applied
    cmd_v[0]  = 4'd1;
    data_v[0] = 32'd9;
    repeat (4) begin
      @(negedge clk);
      chk("reset_d1", 64'(outs(0)), 64'd0);
      chk("reset_d0", 64'(outs(2)), 64'd0);
    end
    rst_n     = 1'b1;
    cmd_v[0]  = '0;
    data_v[0] = '0;
    @(negedge clk);
    chk("post_reset_idle", 64'(outs(0)), 64'd0);

    send(0, 4'd1, 32'd1,         32'h01FF_FFFF, 2'd1, 32'h0200_0000, 1'b0);
    // Add overflow and its boundaries
    send(0, 4'd1, 32'hFFFF_FFFF, 32'd1,         2'd2, 32'd0,         1'b0);
    send(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE, 1'b0);
    send(0, 4'd1, 32'hFFFF_FFFF, 32'd0,         2'd1, 32'hFFFF_FFFF, 1'b0);
    // Subtract underflow, equal operands, normal
    send(0, 4'd2, 32'd1,         32'hF,         2'd2, 32'd0,         1'b0);
    send(0, 4'd2, 32'h10,        32'd1,         2'd1, 32'hF,         1'b0);
    send(0, 4'd2, 32'h55,        32'h55,        2'd1, 32'd0,         1'b0);
    // Invalid commands
    send(0, 4'd3, 32'd5,         32'd6,         2'd2, 32'd0,         1'b0);
    send(0, 4'd4, 32'd5,         32'd6,         2'd2, 32'd0,         1'b0);
    send(0, 4'd15, 32'd5,        32'd6,         2'd2, 32'd0,         1'b0);

    // Shift sweep
    for (int k = 0; k <= 30; k++) begin
      send(0, 4'd5, 32'd1 << k, 32'd1, 2'd1, 32'd1 << (k + 1), 1'b0);
    end
    send(0, 4'd5, 32'd1,         32'h20,        2'd1, 32'd1,         1'b0);
    send(0, 4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'd1,         1'b0);
    send(0, 4'd6, 32'h0000_00F0, 32'h24,        2'd1, 32'hF,         1'b0);
    send(0, 4'd5, 32'hC000_0001, 32'd1,         2'd1, 32'h8000_0002, 1'b0);

    // Request during busy is dropped, for each delay setting
    send(1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b1);
    send(2, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b1);
    send(2, 4'd2, 32'd1, 32'd2, 2'd2, 32'd0, 1'b0);
    send(1, 4'd6, 32'hFFFF_FFFF, 32'd4, 2'd1, 32'h0FFF_FFFF, 1'b0);

    // Reset during the wait state aborts the request
    @(negedge clk);
    cmd_v[1]  = 4'd1;
    data_v[1] = 32'd100;
    @(negedge clk);
    data_v[1] = 32'd1;
    cmd_v[1]  = '0;
    @(negedge clk);
    data_v[1] = '0;
    chk("abort_wait_busy", 64'(outs(1)), 64'({1'b1, 2'd0, 32'd0}));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_reset_now", 64'(outs(1)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_resp", 64'(outs(1)), 64'd0);
    end
    send(1, 4'd1, 32'd7, 32'd8, 2'd1, 32'hF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
